fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h1c000000, meaning the first fetch address after reset.
REQ-002 SHALL provide parameter IBUF_DEPTH, default 2, meaning the number of instruction-buffer entries (power of two, 2..8).
REQ-003 SHALL provide port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL provide port resetn, input, 1, the reset: synchronous, active-low.
REQ-005 SHALL provide port inst_sram_req, output, 1, the fetch request valid.
REQ-006 SHALL provide port inst_sram_wr, output, 1, tied 0.
REQ-007 SHALL provide port inst_sram_addr, output, 32, the fetch address, equal to the current pc.
REQ-008 SHALL provide port inst_sram_addr_ok, input, 1, the request accepted.
REQ-009 SHALL provide port inst_sram_data_ok, input, 1, the read data returned.
REQ-010 SHALL provide port inst_sram_rdata, input, 32, the instruction word.
REQ-011 SHALL provide port ds_allowin, input, 1, decode can accept.
REQ-012 SHALL provide ports br_taken (input, 1) and br_target (input, 32): branch redirect from decode.
REQ-013 SHALL provide ports flush (input, 1) and flush_target (input, 32): exception/ertn redirect.
REQ-014 SHALL provide port fs_to_ds_valid, output, 1, a buffer head entry is available.
REQ-015 SHALL provide port fs_to_ds_bus, output, 65, formatted as {adef, inst[31:0], pc[31:0]}.

Function
REQ-016 SHALL hold a pc register; each request/addr_ok handshake SHALL advance pc to pc+4 (32-bit wrap) and record the request pc.
REQ-017 SHALL allow at most one outstanding request; a request SHALL only be raised while (buffer count + outstanding) < IBUF_DEPTH, so the buffer never overflows.
REQ-018 SHALL keep inst_sram_req and inst_sram_addr stable until addr_ok unless a redirect occurs; a redirect SHALL replace inst_sram_addr with the new target in the same cycle.
REQ-019 On data_ok with no cancel pending, SHALL push {1'b0, rdata, recorded pc} into the FIFO buffer.
REQ-020 On redirect (flush or br_taken), SHALL load pc with the target, clear the buffer, and set cancel if a request is outstanding or addr_ok handshakes in that same cycle.
REQ-021 flush SHALL take priority over br_taken when both are asserted.
REQ-022 While cancel is set, the next data_ok SHALL be discarded and clear cancel; no new request SHALL be raised until then.
REQ-023 A redirect in the same cycle as data_ok SHALL discard that data.
REQ-024 fs_to_ds_valid SHALL be asserted when the buffer is non-empty and no redirect is asserted; the bus SHALL present the head entry.
REQ-025 Pop SHALL occur when fs_to_ds_valid and ds_allowin are both high; a simultaneous push and pop SHALL keep the count unchanged.
REQ-026 Minimum latency SHALL be: addr_ok in cycle N, data_ok in cycle N+1, fs_to_ds_valid in cycle N+2.

Reset
REQ-027 With resetn low, the block SHALL set pc=RESET_PC and clear the buffer, outstanding and cancel; inst_sram_req=0, fs_to_ds_valid=0, fs_to_ds_bus=0.
REQ-028 inst_sram_req SHALL first assert in the cycle after resetn rises; data_ok for a request made before reset SHALL be ignored.

Configuration
REQ-029 With macro FETCH_ADEF_EN defined, a pc with pc[1:0]!=0 SHALL raise no request; instead it SHALL push {1'b1, 32'h0, pc} when buffer space allows, and then hold fetch until a redirect.
REQ-030 Without FETCH_ADEF_EN, adef SHALL be tied 0 and misaligned pcs SHALL be fetched as normal.

Verification
REQ-031 Reset release, addr_ok and data_ok always 1, ds_allowin=1 -> addrs 1c000000, 1c000004, ...; fs_to_ds_valid from cycle 3 with pc=1c000000.
REQ-032 ds_allowin=0 for 10 cycles -> exactly IBUF_DEPTH entries are buffered, req stays low, and the entries drain in order once ds_allowin is released.
REQ-033 br_taken with br_target=1c000100 while a request is outstanding -> the returning data is dropped; the next bus pc is 1c000100.
REQ-034 flush with target 1c008000 in the same cycle as br_taken -> pc=1c008000 and the buffer is empty the next cycle.
REQ-035 FETCH_ADEF_EN defined, br_target=1c000102 -> no request is raised; bus = {1, 0, 1c000102}.
REQ-036 resetn pulsed low while a request is outstanding -> the late data_ok is ignored; the first fetch is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-side bundle: inst_sram request/response channel plus the fetch->decode handshake.
interface fetch_stage_if;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        ds_allowin;
  logic        fs_to_ds_valid;
  logic [64:0] fs_to_ds_bus;

  modport master (
    output inst_sram_req, inst_sram_wr, inst_sram_addr,
    input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    input  ds_allowin,
    output fs_to_ds_valid, fs_to_ds_bus
  );

  modport slave (
    input  inst_sram_req, inst_sram_wr, inst_sram_addr,
    output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata,
    output ds_allowin,
    input  fs_to_ds_valid, fs_to_ds_bus
  );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: one outstanding inst_sram read, IBUF_DEPTH-entry buffer toward decode; addr_ok->valid in 2 cycles.
// Requests stall while buffer+outstanding is full or a cancel is pending. FETCH_ADEF_EN enables misaligned-pc adef entries.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 2
) (
  input  logic          clk,
  input  logic          resetn,
  fetch_stage_if.master fs,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  input  logic          flush,
  input  logic [31:0]   flush_target
);
  localparam int PW = (IBUF_DEPTH > 1) ? $clog2(IBUF_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(IBUF_DEPTH);

  logic [31:0]   pc;
  logic [31:0]   req_pc;
  logic          started;
  logic          outstanding;
  logic          cancel;
  logic [64:0]   ibuf [IBUF_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic          redirect;
  logic [31:0]   redirect_target;
  logic          has_space;
  logic          fetch_ok;
  logic          req;
  logic          handshake;
  logic          data_ret;
  logic          push_data;
  logic          adef_push;
  logic          push;
  logic          pop;
  logic          valid;
  logic [64:0]   push_entry;

  assign redirect        = flush | br_taken;
  assign redirect_target = flush ? flush_target : br_target;

  assign has_space = count < DEPTH;

`ifdef FETCH_ADEF_EN
  logic misaligned;
  logic adef_done;

  // A misaligned pc produces one adef entry, then fetch parks until a redirect.
  assign misaligned = pc[1:0] != 2'b00;
  assign fetch_ok   = ~misaligned;
  assign adef_push  = started & misaligned & ~adef_done & ~outstanding & ~cancel
                    & has_space & ~redirect;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      adef_done <= 1'b0;
    end else if (redirect) begin
      adef_done <= 1'b0;
    end else if (adef_push) begin
      adef_done <= 1'b1;
    end
  end
`else
  assign fetch_ok  = 1'b1;
  assign adef_push = 1'b0;
`endif

  assign req       = resetn & started & ~outstanding & ~cancel & has_space & fetch_ok;
  assign handshake = req & fs.inst_sram_addr_ok;
  // data_ok with nothing outstanding belongs to a request lost across reset.
  assign data_ret  = outstanding & fs.inst_sram_data_ok;
  assign push_data = data_ret & ~cancel & ~redirect;
  assign push      = push_data | adef_push;
  assign push_entry = adef_push ? {1'b1, 32'h0, pc} : {1'b0, fs.inst_sram_rdata, req_pc};

  assign valid = resetn & (count != '0) & ~redirect;
  assign pop   = valid & fs.ds_allowin;

  assign fs.inst_sram_req  = req;
  assign fs.inst_sram_wr   = 1'b0;
  assign fs.inst_sram_addr = redirect ? redirect_target : pc;
  assign fs.fs_to_ds_valid = valid;
  assign fs.fs_to_ds_bus   = (resetn && count != '0) ? ibuf[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      req_pc      <= RESET_PC;
      started     <= 1'b0;
      outstanding <= 1'b0;
      cancel      <= 1'b0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
    end else begin
      started <= 1'b1;
      if (handshake) begin
        req_pc <= fs.inst_sram_addr;
      end
      if (redirect) begin
        pc <= redirect_target;
      end else if (handshake) begin
        pc <= pc + 32'd4;
      end
      outstanding <= handshake | (outstanding & ~fs.inst_sram_data_ok);
      // Cancel tracks a request still in flight past the redirect, including one accepted this cycle.
      if (redirect) begin
        cancel <= handshake | (outstanding & ~fs.inst_sram_data_ok);
      end else if (data_ret) begin
        cancel <= 1'b0;
      end
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (push && !pop) begin
          count <= count + CW'(1);
        end else if (pop && !push) begin
          count <= count - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ibuf[wr_ptr] <= push_entry;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a one-deep inst_sram responder and default parameters.
module tb_fetch_stage;
  localparam logic [31:0] RPC  = 32'h1c000000;
  localparam logic [31:0] MASK = 32'ha5a50000;

  logic        clk;
  logic        resetn;
  logic        br_taken;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_target;
  logic        aok_en;
  logic        dok_en;
  logic        pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  int          total = 0;
  int          bad = 0;

  fetch_stage_if ifc();

  fetch_stage dut (
    .clk          (clk),
    .resetn       (resetn),
    .fs           (ifc),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .flush        (flush),
    .flush_target (flush_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory side: returns rdata = addr ^ MASK, data_ok gated by dok_en; not reset with the DUT.
  assign ifc.inst_sram_addr_ok = aok_en;
  assign ifc.inst_sram_data_ok = pend & dok_en;
  assign ifc.inst_sram_rdata   = pend_addr ^ MASK;

  always @(posedge clk) begin
    if (ifc.inst_sram_req && ifc.inst_sram_addr_ok) begin
      pend      <= 1'b1;
      pend_addr <= ifc.inst_sram_addr;
    end else if (ifc.inst_sram_data_ok) begin
      pend <= 1'b0;
    end
  end

  function automatic logic [64:0] ent(input logic adef, input logic [31:0] inst, input logic [31:0] p);
    return {adef, inst, p};
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn = 1'b0; br_taken = 1'b0; br_target = '0; flush = 1'b0; flush_target = '0;
    aok_en = 1'b0; dok_en = 1'b0; ifc.ds_allowin = 1'b0;
    tick(); tick();
    chk("rst_req",   65'(ifc.inst_sram_req), 65'(1'b0));
    chk("rst_wr",    65'(ifc.inst_sram_wr), 65'(1'b0));
    chk("rst_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    chk("rst_bus",   ifc.fs_to_ds_bus, 65'h0);
    chk("rst_addr",  65'(ifc.inst_sram_addr), 65'(RPC));

    // Streaming after reset release.
    resetn = 1'b1; aok_en = 1'b1; dok_en = 1'b1; ifc.ds_allowin = 1'b1;
    #1;
    chk("c0_req", 65'(ifc.inst_sram_req), 65'(1'b0));
    tick();
    chk("c1_req",  65'(ifc.inst_sram_req), 65'(1'b1));
    chk("c1_addr", 65'(ifc.inst_sram_addr), 65'(RPC));
    tick();
    chk("c2_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    tick();
    chk("c3_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b1));
    chk("c3_bus",   ifc.fs_to_ds_bus, ent(1'b0, RPC ^ MASK, RPC));
    chk("c3_addr",  65'(ifc.inst_sram_addr), 65'(RPC + 32'd4));
    tick();
    chk("c4_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    tick();
    chk("c5_bus",   ifc.fs_to_ds_bus, ent(1'b0, (RPC + 32'd4) ^ MASK, RPC + 32'd4));

    // Decode stall: buffer fills to depth and requests stop.
    ifc.ds_allowin = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_req", 65'(ifc.inst_sram_req), 65'(1'b0));
    end
    chk("stall_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b1));
    chk("stall_head",  ifc.fs_to_ds_bus, ent(1'b0, (RPC + 32'd4) ^ MASK, RPC + 32'd4));
    ifc.ds_allowin = 1'b1;
    tick();
    chk("drain2_bus",  ifc.fs_to_ds_bus, ent(1'b0, (RPC + 32'd8) ^ MASK, RPC + 32'd8));
    chk("drain2_addr", 65'(ifc.inst_sram_addr), 65'(RPC + 32'hc));
    tick();
    chk("drain_empty", 65'(ifc.fs_to_ds_valid), 65'(1'b0));

    // Branch while the 0c request is outstanding: its data must be dropped.
    dok_en = 1'b0;
    tick();
    br_taken = 1'b1; br_target = 32'h1c000100;
    #1;
    chk("br_addr",  65'(ifc.inst_sram_addr), 65'(32'h1c000100));
    chk("br_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    tick();
    br_taken = 1'b0; dok_en = 1'b1;
    #1;
    chk("br_cancel_req", 65'(ifc.inst_sram_req), 65'(1'b0));
    tick();
    chk("br_req",  65'(ifc.inst_sram_req), 65'(1'b1));
    chk("br_addr2", 65'(ifc.inst_sram_addr), 65'(32'h1c000100));
    tick(); tick();
    chk("br_bus", ifc.fs_to_ds_bus, ent(1'b0, 32'h1c000100 ^ MASK, 32'h1c000100));

    // Flush and branch together: flush target wins, buffer emptied.
    flush = 1'b1; flush_target = 32'h1c008000; br_taken = 1'b1; br_target = 32'h1c000200;
    #1;
    chk("fl_addr", 65'(ifc.inst_sram_addr), 65'(32'h1c008000));
    tick();
    flush = 1'b0; br_taken = 1'b0;
    #1;
    chk("fl_empty", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    chk("fl_pc",    65'(ifc.inst_sram_addr), 65'(32'h1c008000));
    chk("fl_req",   65'(ifc.inst_sram_req), 65'(1'b0));
    tick();
    chk("fl_req2", 65'(ifc.inst_sram_req), 65'(1'b1));
    tick(); tick();
    chk("fl_bus", ifc.fs_to_ds_bus, ent(1'b0, 32'h1c008000 ^ MASK, 32'h1c008000));

    // Redirect in the same cycle as data_ok: data dropped, no cancel left behind.
    tick();
    br_taken = 1'b1; br_target = 32'h1c000300;
    tick();
    br_taken = 1'b0;
    #1;
    chk("same_req",   65'(ifc.inst_sram_req), 65'(1'b1));
    chk("same_addr",  65'(ifc.inst_sram_addr), 65'(32'h1c000300));
    chk("same_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    tick(); tick();
    chk("same_bus", ifc.fs_to_ds_bus, ent(1'b0, 32'h1c000300 ^ MASK, 32'h1c000300));

    // Reset with a request in flight; its late data_ok lands after release.
    dok_en = 1'b0;
    tick();
    resetn = 1'b0;
    tick();
    chk("rr_req",   65'(ifc.inst_sram_req), 65'(1'b0));
    chk("rr_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    chk("rr_bus",   ifc.fs_to_ds_bus, 65'h0);
    tick();
    resetn = 1'b1; dok_en = 1'b1;
    #1;
    chk("rr_c0_req", 65'(ifc.inst_sram_req), 65'(1'b0));
    tick();
    chk("rr_req1",  65'(ifc.inst_sram_req), 65'(1'b1));
    chk("rr_addr1", 65'(ifc.inst_sram_addr), 65'(RPC));
    chk("rr_nolate", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    tick(); tick();
    chk("rr_bus1", ifc.fs_to_ds_bus, ent(1'b0, RPC ^ MASK, RPC));

    // Misaligned branch target.
    br_taken = 1'b1; br_target = 32'h1c000102;
    #1;
    chk("mis_addr", 65'(ifc.inst_sram_addr), 65'(32'h1c000102));
    tick();
    br_taken = 1'b0;
    #1;
    chk("mis_cancel_req", 65'(ifc.inst_sram_req), 65'(1'b0));
    tick();
`ifdef FETCH_ADEF_EN
    chk("adef_req", 65'(ifc.inst_sram_req), 65'(1'b0));
    tick();
    chk("adef_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b1));
    chk("adef_bus",   ifc.fs_to_ds_bus, ent(1'b1, 32'h0, 32'h1c000102));
    chk("adef_req2",  65'(ifc.inst_sram_req), 65'(1'b0));
    tick();
    chk("adef_hold_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    chk("adef_hold_req",   65'(ifc.inst_sram_req), 65'(1'b0));
`else
    chk("mis_req",  65'(ifc.inst_sram_req), 65'(1'b1));
    chk("mis_addr2", 65'(ifc.inst_sram_addr), 65'(32'h1c000102));
    tick();
    chk("mis_valid", 65'(ifc.fs_to_ds_valid), 65'(1'b0));
    tick();
    chk("mis_bus", ifc.fs_to_ds_bus, ent(1'b0, 32'h1c000102 ^ MASK, 32'h1c000102));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
